iqueue_param: RTL

Parametrised instruction queue between IFetch and the decode/issue stage. It buffers fetched instruction/PC pairs in a circular FIFO of configurable depth and width, and presents the head entry for issue under a valid/ready handshake. Over the original fixed 16-entry queue it adds:
- an exact occupancy count;
- a programmable almost-full back-pressure threshold that covers fetch requests already in flight;
- a single-cycle flush for branch redirect;
- a sticky overflow error flag.

---
 rtl/iqueue_param.sv | 82 ++++++++
 1 files changed

// File: rtl/iqueue_param.sv
// Instruction queue between fetch and decode/issue: circular FIFO of inst/PC
// pairs with exact occupancy, almost-full stall, single-cycle flush, overflow flag.
module iqueue_param #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int SLACK  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     inst_rdy,
    input  logic [INST_W-1:0]        inst,
    input  logic [PC_W-1:0]          pc_in,
    output logic                     full_stall,
    output logic                     issue_valid,
    output logic [INST_W-1:0]        issue_inst,
    output logic [PC_W-1:0]          issue_pc,
    input  logic                     issue_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SLACK);

    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [PC_W-1:0]   mem_pc   [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          full;
    logic          enq;
    logic          deq;
    logic          ovf_hit;

    assign full        = (count == FULL_CNT);
    assign issue_valid = (count != '0);
    assign full_stall  = (count >= STALL_CNT);
    assign issue_inst  = mem_inst[head];
    assign issue_pc    = mem_pc[head];

    // A dequeue at full frees the head slot, so the enqueue may reuse it.
    assign deq     = rdy && issue_valid && issue_ready && !flush;
    assign enq     = rdy && inst_rdy && !flush && (!full || deq);
    assign ovf_hit = rdy && inst_rdy && !flush && full && !deq;

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_inst[tail] <= inst;
            mem_pc[tail]   <= pc_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (enq) tail <= tail + 1'b1;
                if (deq) head <= head + 1'b1;
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (ovf_hit) overflow_err <= 1'b1;
            end
        end
    end

endmodule
